// File: rtl/serv_rf_dbg_arb.sv
// Arbitrates the SERV register-file RAM between the core RF interface and a debug
// port that moves whole 32-bit registers/CSRs as N consecutive RAM words.
module serv_rf_dbg_arb #(
  parameter int unsigned RF_WIDTH  = 8,
  parameter int unsigned CSR_REGS  = 4,
  parameter int unsigned RF_L2D    = $clog2((32+CSR_REGS)*32/RF_WIDTH),
  parameter int unsigned CORE_HOLD = 40
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_core_rreq,
  input  logic                i_core_wreq,
  output logic                o_core_ready,
  output logic                o_ifc_rreq,
  output logic                o_ifc_wreq,
  input  logic                i_ifc_ready,
  input  logic [RF_L2D-1:0]   i_ifc_waddr,
  input  logic [RF_L2D-1:0]   i_ifc_raddr,
  input  logic [RF_WIDTH-1:0] i_ifc_wdata,
  input  logic                i_ifc_wen,
  input  logic                i_ifc_ren,
  output logic [RF_WIDTH-1:0] o_ifc_rdata,
  output logic [RF_L2D-1:0]   o_waddr,
  output logic [RF_L2D-1:0]   o_raddr,
  output logic [RF_WIDTH-1:0] o_wdata,
  output logic                o_wen,
  output logic                o_ren,
  input  logic [RF_WIDTH-1:0] i_rdata,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [5:0]          i_dbg_reg,
  input  logic [31:0]         i_dbg_wdat,
  output logic                o_dbg_ack,
  output logic [31:0]         o_dbg_rdat
);

  localparam int unsigned N      = 32 / RF_WIDTH;
  localparam int unsigned CW     = $clog2(N);
  localparam int unsigned IW     = $clog2(CORE_HOLD + 1);
  localparam int unsigned AW     = 32 - RF_WIDTH;
  localparam int unsigned MAXREG = 31 + CSR_REGS;

  typedef enum logic [1:0] {S_IDLE, S_CORE, S_DBG_RUN, S_DBG_DONE} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idle;
  logic                r_pend_r, r_pend_w;
  logic [AW-1:0]       r_acc;
  logic [31:0]         r_rdat;

  logic                w_fwd_r, w_fwd_w, w_set_pend, w_clr_pend;
  logic                w_core_req, w_core_act, w_hold_out, w_dbg_sel, w_dbg_valid;
  logic [RF_L2D-1:0]   w_dbg_addr;
  logic [5:0]          w_sh;
  logic [RF_WIDTH-1:0] w_dbg_word;
  logic [31:0]         w_rdat_new;

  assign w_core_req  = i_core_rreq | i_core_wreq;
  assign w_core_act  = w_core_req | i_ifc_ready | i_ifc_ren | i_ifc_wen;
  assign w_hold_out  = (r_idle == IW'(CORE_HOLD));
  assign w_dbg_valid = (i_dbg_reg != '0) && (32'(i_dbg_reg) <= MAXREG);
  assign w_dbg_addr  = RF_L2D'(i_dbg_reg) * RF_L2D'(N) + RF_L2D'(r_cnt);
  assign w_sh        = 6'(r_cnt) * 6'(RF_WIDTH);
  assign w_dbg_word  = RF_WIDTH'(i_dbg_wdat >> w_sh);
  // Last word arrives from the RAM during DBG_DONE; merge it so data is valid with ack.
  assign w_rdat_new  = w_dbg_valid ? {i_rdata, r_acc} : '0;

  // Next-state, core forwarding and pending control
  always_comb begin
    w_next     = r_state;
    w_fwd_r    = 1'b0;
    w_fwd_w    = 1'b0;
    w_set_pend = 1'b0;
    w_clr_pend = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_core_req | r_pend_r | r_pend_w) begin
          w_fwd_r    = i_core_rreq | r_pend_r;
          w_fwd_w    = i_core_wreq | r_pend_w;
          w_clr_pend = 1'b1;
          w_next     = S_CORE;
        end else if (i_dbg_req) begin
          w_next = S_DBG_RUN;
        end
      end
      S_CORE: begin
        if (w_hold_out && i_dbg_req) begin
          w_set_pend = 1'b1;
          w_next     = S_DBG_RUN;
        end else begin
          w_fwd_r = i_core_rreq;
          w_fwd_w = i_core_wreq;
          if (w_hold_out && !w_core_req) w_next = S_IDLE;
        end
      end
      S_DBG_RUN: begin
        w_set_pend = 1'b1;
        if (r_cnt == CW'(N - 1)) w_next = S_DBG_DONE;
      end
      S_DBG_DONE: begin
        w_set_pend = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idle   <= '0;
      r_pend_r <= 1'b0;
      r_pend_w <= 1'b0;
      r_acc    <= '0;
      r_rdat   <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == S_DBG_RUN) r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
      else                      r_cnt <= '0;

      if (r_state != S_CORE || w_core_act) r_idle <= '0;
      else if (!w_hold_out)                r_idle <= r_idle + IW'(1);

      if (w_clr_pend) begin
        r_pend_r <= 1'b0;
        r_pend_w <= 1'b0;
      end else if (w_set_pend) begin
        r_pend_r <= r_pend_r | i_core_rreq;
        r_pend_w <= r_pend_w | i_core_wreq;
      end

      // Word c-1 is on i_rdata while the counter shows c
      if (r_state == S_DBG_RUN && r_cnt != '0) r_acc <= AW'({i_rdata, r_acc} >> RF_WIDTH);

      if (r_state == S_DBG_DONE && !i_dbg_we) r_rdat <= w_rdat_new;
    end
  end

  assign w_dbg_sel    = (r_state == S_DBG_RUN) || (r_state == S_DBG_DONE);
  assign o_waddr      = w_dbg_sel ? w_dbg_addr : i_ifc_waddr;
  assign o_raddr      = w_dbg_sel ? w_dbg_addr : i_ifc_raddr;
  assign o_wdata      = w_dbg_sel ? w_dbg_word : i_ifc_wdata;
  assign o_wen        = w_dbg_sel ? (r_state == S_DBG_RUN && i_dbg_we && w_dbg_valid) : i_ifc_wen;
  assign o_ren        = w_dbg_sel ? (r_state == S_DBG_RUN && !i_dbg_we && w_dbg_valid) : i_ifc_ren;
  assign o_ifc_rdata  = i_rdata;
  assign o_core_ready = i_ifc_ready;
  assign o_ifc_rreq   = w_fwd_r;
  assign o_ifc_wreq   = w_fwd_w;
  assign o_dbg_ack    = (r_state == S_DBG_DONE);
  assign o_dbg_rdat   = (r_state == S_DBG_DONE && !i_dbg_we) ? w_rdat_new : r_rdat;

endmodule
